// File: rtl/register_bank_pkg.sv
// Shared definitions for the register bank of the pipelined MIPS core.
// Holds the dump FSM state encoding, the hard-zero register index and
// the default widths used by the other pipeline stages.
package register_bank_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned NUM_REGS_DEF   = 32;
    localparam int unsigned ADDR_WIDTH_DEF = 5;

    // Index of the hardwired-zero register.
    localparam int unsigned REG_ZERO = 0;

    typedef logic [1:0] dump_state_t;

    localparam dump_state_t ST_IDLE = 2'd0;
    localparam dump_state_t ST_SEND = 2'd1;
    localparam dump_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/register_bank_dump_seq.sv
// Dump sequencer: walks every register index and offers each value to
// the debug unit over a valid/ready handshake, then pulses done.
// Ports:
//   i_clk, i_reset           clock, async active-high reset
//   i_dump_start             start request (honoured only when idle)
//   i_dump_ready             debug unit accepts the offered word
//   o_rd_idx / i_rd_data     read index into the array and its raw value
//   o_dump_data/valid/busy/done  handshake and status outputs
module reg_dump_seq
    import register_bank_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned NUM_REGS   = NUM_REGS_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_dump_start,
    input  logic                  i_dump_ready,
    output logic [ADDR_WIDTH-1:0] o_rd_idx,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic [DATA_WIDTH-1:0] o_dump_data,
    output logic                  o_dump_valid,
    output logic                  o_dump_busy,
    output logic                  o_dump_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

    dump_state_t           state;
    logic [ADDR_WIDTH-1:0] idx;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_dump_start) begin
                        idx   <= '0;
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // The last index moves to DONE instead of wrapping.
                    if (i_dump_ready) begin
                        if (idx == LAST_IDX) begin
                            state <= ST_DONE;
                        end else begin
                            idx <= idx + ONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    idx   <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Outputs decode straight from state so an async reset clears
    // them immediately.
    assign o_rd_idx     = idx;
    assign o_dump_valid = (state == ST_SEND);
    assign o_dump_done  = (state == ST_DONE);
    assign o_dump_busy  = o_dump_valid | o_dump_done;
    assign o_dump_data  = o_dump_valid ? i_rd_data : '0;

endmodule

// File: rtl/register_bank.sv
// General-purpose register file: two combinational read ports with
// write-through, one synchronous write port, r0 hardwired to zero,
// and a dump sequencer streaming all registers to the debug unit.
// Ports:
//   i_clk, i_reset                      clock, async active-high reset
//   i_read_reg_1/2, o_read_data_1/2     operand read ports (rs, rt)
//   i_write_reg, i_WB_data, i_WB_write  write-back port
//   i_dump_start, i_dump_ready          dump control / handshake in
//   o_dump_data/valid/busy/done         dump handshake / status out
module register_bank
    import register_bank_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned NUM_REGS   = NUM_REGS_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [ADDR_WIDTH-1:0] i_read_reg_1,
    input  logic [ADDR_WIDTH-1:0] i_read_reg_2,
    output logic [DATA_WIDTH-1:0] o_read_data_1,
    output logic [DATA_WIDTH-1:0] o_read_data_2,
    input  logic [ADDR_WIDTH-1:0] i_write_reg,
    input  logic [DATA_WIDTH-1:0] i_WB_data,
    input  logic                  i_WB_write,
    input  logic                  i_dump_start,
    output logic [DATA_WIDTH-1:0] o_dump_data,
    output logic                  o_dump_valid,
    input  logic                  i_dump_ready,
    output logic                  o_dump_busy,
    output logic                  o_dump_done
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [ADDR_WIDTH-1:0] dump_idx;
    logic [DATA_WIDTH-1:0] dump_word;
    logic                  wr_en;

    assign wr_en = i_WB_write && (i_write_reg != ZERO_IDX);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[i_write_reg] <= i_WB_data;
        end
    end

    // Write-through forwards the WB value so decode sees it this cycle.
    always_comb begin
        o_read_data_1 = regs[i_read_reg_1];
        if (i_read_reg_1 == ZERO_IDX) begin
            o_read_data_1 = '0;
        end else if (wr_en && (i_write_reg == i_read_reg_1)) begin
            o_read_data_1 = i_WB_data;
        end
    end

    always_comb begin
        o_read_data_2 = regs[i_read_reg_2];
        if (i_read_reg_2 == ZERO_IDX) begin
            o_read_data_2 = '0;
        end else if (wr_en && (i_write_reg == i_read_reg_2)) begin
            o_read_data_2 = i_WB_data;
        end
    end

    // The dump sees raw array contents only, never the forwarded value.
    assign dump_word = (dump_idx == ZERO_IDX) ? '0 : regs[dump_idx];

    reg_dump_seq #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_REGS  (NUM_REGS),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_dump_seq (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_dump_start(i_dump_start),
        .i_dump_ready(i_dump_ready),
        .o_rd_idx    (dump_idx),
        .i_rd_data   (dump_word),
        .o_dump_data (o_dump_data),
        .o_dump_valid(o_dump_valid),
        .o_dump_busy (o_dump_busy),
        .o_dump_done (o_dump_done)
    );

endmodule

// File: tb/tb_register_bank.sv
// Directed self-checking bench for register_bank: reset, r0, write,
// write-through, dumps with and without stalls, mid-dump writes/reset.
module tb_register_bank;

    logic        clk;
    logic        rst;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        we;
    logic        dstart;
    logic [31:0] ddata;
    logic        dvalid;
    logic        dready;
    logic        dbusy;
    logic        ddone;

    int n_checks;
    int n_errors;

    logic [31:0] mdl [32];
    logic [31:0] exp_w [32];

    register_bank dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_read_reg_1 (rr1),
        .i_read_reg_2 (rr2),
        .o_read_data_1(rd1),
        .o_read_data_2(rd2),
        .i_write_reg  (wreg),
        .i_WB_data    (wdata),
        .i_WB_write   (we),
        .i_dump_start (dstart),
        .o_dump_data  (ddata),
        .o_dump_valid (dvalid),
        .i_dump_ready (dready),
        .o_dump_busy  (dbusy),
        .o_dump_done  (ddone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        wreg  = a;
        wdata = d;
        we    = 1'b1;
        step();
        we = 1'b0;
        if (a != 5'd0) mdl[a] = d;
    endtask

    // mode 0: ready high; 1: ready toggles + stray start;
    // 2: writes r3/r20 around idx 10; 3: reset at idx 12.
    task automatic run_dump(input int mode);
        int n;
        int c;
        int done_cnt;
        int done_cyc;
        bit rst_hit;
        bit finished;
        n        = 0;
        c        = 1;
        done_cnt = 0;
        done_cyc = 0;
        rst_hit  = 0;
        finished = 0;
        for (int i = 0; i < 32; i++) exp_w[i] = mdl[i];
        dready = 1'b1;
        dstart = 1'b1;
        step();
        dstart = 1'b0;
        check("valid_rise", {31'd0, dvalid}, 32'd1);
        for (int k = 0; k < 200; k++) begin
            dready = (mode == 1) ? ((c % 2) == 1) : 1'b1;
            dstart = (mode == 1 && c == 6) ? 1'b1 : 1'b0;
            we     = 1'b0;
            if (mode == 2 && n == 10 && dvalid) begin
                wreg = 5'd3; wdata = 32'h0000_CAFE; we = 1'b1;
                mdl[3] = 32'h0000_CAFE;
            end
            if (mode == 2 && n == 11 && dvalid) begin
                wreg = 5'd20; wdata = 32'h0000_BEEF; we = 1'b1;
                mdl[20] = 32'h0000_BEEF;
                exp_w[20] = 32'h0000_BEEF;
            end
            if (mode == 3 && n == 12) begin
                rst = 1'b1;
                #1;
                check("rst_valid", {31'd0, dvalid}, 32'd0);
                check("rst_busy", {31'd0, dbusy}, 32'd0);
                check("rst_done", {31'd0, ddone}, 32'd0);
                check("rst_data", ddata, 32'd0);
                step();
                rst = 1'b0;
                for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
                rst_hit = 1;
                break;
            end
            #1;
            if (ddone) begin
                done_cnt++;
                done_cyc = c;
            end
            if (dvalid) begin
                if (n < 32) check($sformatf("dump_w%0d", n), ddata, exp_w[n]);
                if (dready) n++;
            end else if (!dbusy) begin
                finished = 1;
                break;
            end
            step();
            dstart = 1'b0;
            c++;
        end
        we     = 1'b0;
        dstart = 1'b0;
        if (mode == 3) begin
            check("rst_hit", {31'd0, rst_hit}, 32'd1);
            check("rst_no_done", done_cnt, 0);
        end else begin
            check("dump_finished", {31'd0, finished}, 32'd1);
            check("dump_words", n, 32);
            check("done_count", done_cnt, 1);
            if (mode == 0) check("done_cycle", done_cyc, 33);
            check("busy_after", {31'd0, dbusy}, 32'd0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        rst    = 1'b1;
        rr1    = 5'd1;
        rr2    = 5'd31;
        wreg   = 5'd0;
        wdata  = 32'd0;
        we     = 1'b0;
        dstart = 1'b0;
        dready = 1'b0;
        #2;
        check("reset_r1", rd1, 32'd0);
        check("reset_r31", rd2, 32'd0);
        check("reset_valid", {31'd0, dvalid}, 32'd0);
        check("reset_busy", {31'd0, dbusy}, 32'd0);
        check("reset_done", {31'd0, ddone}, 32'd0);
        check("reset_ddata", ddata, 32'd0);
        step();
        rst = 1'b0;
        step();

        // r0 stays zero, even while being written
        rr1 = 5'd0;
        wreg = 5'd0; wdata = 32'hDEAD_BEEF; we = 1'b1;
        #1;
        check("r0_wt", rd1, 32'd0);
        step();
        we = 1'b0;
        #1;
        check("r0_read", rd1, 32'd0);

        // plain write then read next cycle
        write_reg(5'd5, 32'h1234_5678);
        rr1 = 5'd5;
        rr2 = 5'd6;
        #1;
        check("r5_read", rd1, 32'h1234_5678);
        check("r6_untouched", rd2, 32'd0);

        // same-cycle write-through on both ports
        rr1 = 5'd7; rr2 = 5'd7;
        wreg = 5'd7; wdata = 32'hA5A5_A5A5; we = 1'b1;
        #1;
        check("wt_port1", rd1, 32'hA5A5_A5A5);
        check("wt_port2", rd2, 32'hA5A5_A5A5);
        step();
        we = 1'b0;
        mdl[7] = 32'hA5A5_A5A5;

        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i * 32'h11));
        rr1 = 5'd31;
        #1;
        check("r31_load", rd1, 32'h0000_020F);

        run_dump(0);
        run_dump(1);
        run_dump(2);
        rr1 = 5'd3; rr2 = 5'd20;
        #1;
        check("r3_after", rd1, 32'h0000_CAFE);
        check("r20_after", rd2, 32'h0000_BEEF);

        run_dump(3);
        rr1 = 5'd5; rr2 = 5'd31;
        #1;
        check("r5_cleared", rd1, 32'd0);
        check("r31_cleared", rd2, 32'd0);
        run_dump(0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
